// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock and its auto-set sequencer.
// Contents:
//   MIN_N, HRS_N, DYS_N, MONTH_N  counter moduli
//   field_t                       set-field walk order (month first: date range depends on it)
//   state_t                       auto-set sequencer states
//   days_in_month()               date modulus for a 0-based month, also used by the date counter
package clock_pkg;

    localparam logic [6:0] MIN_N   = 7'd60;
    localparam logic [6:0] HRS_N   = 7'd24;
    localparam logic [6:0] DYS_N   = 7'd7;
    localparam logic [6:0] MONTH_N = 7'd12;

    typedef enum logic [2:0] {
        F_MONTH,
        F_DATE,
        F_DAY,
        F_HRS,
        F_MIN
    } field_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CMP,
        S_ADV,
        S_DONE,
        S_ERR
    } state_t;

    // Month is 0-based: 1 = Feb, 3/5/8/10 = Apr/Jun/Sep/Nov.
    function automatic logic [6:0] days_in_month(input logic [6:0] month);
        case (month)
            7'd1:                    days_in_month = 7'd28;
            7'd3, 7'd5, 7'd8, 7'd10: days_in_month = 7'd30;
            default:                 days_in_month = 7'd31;
        endcase
    endfunction

endpackage

// File: rtl/clock_autoset_if.sv
// Bus between the auto-set sequencer and its surroundings.
// Signals:
//   start, abort                      sequence control
//   tgt_*                             requested setting (0-based)
//   cur_*                             live clock counter values
//   Timeset, *adv                     drives to the clock's manual set inputs
//   busy, done, err                   sequencer status
// Modports: master (controller/clock side), slave (the sequencer).
interface clock_autoset_if;

    logic       start;
    logic       abort;
    logic [6:0] tgt_min;
    logic [6:0] tgt_hrs;
    logic [6:0] tgt_dys;
    logic [6:0] tgt_date;
    logic [6:0] tgt_month;
    logic [6:0] cur_min;
    logic [6:0] cur_hrs;
    logic [6:0] cur_dys;
    logic [6:0] cur_date;
    logic [6:0] cur_month;
    logic       Timeset;
    logic       Monthadv;
    logic       Dateadv;
    logic       Dayadv;
    logic       Hrsadv;
    logic       Minadv;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, abort,
        output tgt_min, tgt_hrs, tgt_dys, tgt_date, tgt_month,
        output cur_min, cur_hrs, cur_dys, cur_date, cur_month,
        input  Timeset, Monthadv, Dateadv, Dayadv, Hrsadv, Minadv,
        input  busy, done, err
    );

    modport slave (
        input  start, abort,
        input  tgt_min, tgt_hrs, tgt_dys, tgt_date, tgt_month,
        input  cur_min, cur_hrs, cur_dys, cur_date, cur_month,
        output Timeset, Monthadv, Dateadv, Dayadv, Hrsadv, Minadv,
        output busy, done, err
    );

endinterface

// File: rtl/clock_autoset.sv
// Auto-set sequencer: stands in for a human on the clock's set buttons.
// Captures a target month/date/day/hour/minute, validates it, then walks the
// fields month -> date -> day -> hrs -> min, issuing one advance strobe at a
// time until the clock's live counter matches, and reports done or err.
// Ports:
//   clk   clock, shared with the clock counters (Pulse)
//   rst   asynchronous active-high reset
//   bus   clock_autoset_if.slave (start/abort, targets, live values,
//         Timeset + advance strobes, busy/done/err)
module clock_autoset (
    input  logic             clk,
    input  logic             rst,
    clock_autoset_if.slave   bus
);

    import clock_pkg::*;

    state_t     state;
    field_t     field;
    logic [5:0] step;

    logic [6:0] t_min;
    logic [6:0] t_hrs;
    logic [6:0] t_dys;
    logic [6:0] t_date;
    logic [6:0] t_month;

    logic       timeset_r;
    logic       busy_r;
    logic       done_r;
    logic       err_r;
    logic [4:0] strb_r;     // one-hot, bit index = field_t value

    logic [6:0] sel_tgt;
    logic [6:0] sel_cur;
    logic [6:0] sel_mod;
    logic       range_bad;
    logic       field_match;
    logic       step_spent;

    function automatic field_t next_field(input field_t f);
        case (f)
            F_MONTH: next_field = F_DATE;
            F_DATE:  next_field = F_DAY;
            F_DAY:   next_field = F_HRS;
            default: next_field = F_MIN;
        endcase
    endfunction

    function automatic logic [4:0] field_onehot(input field_t f);
        case (f)
            F_MONTH: field_onehot = 5'b00001;
            F_DATE:  field_onehot = 5'b00010;
            F_DAY:   field_onehot = 5'b00100;
            F_HRS:   field_onehot = 5'b01000;
            default: field_onehot = 5'b10000;
        endcase
    endfunction

    // Field-indexed selection of target, live value and modulus.
    always_comb begin
        sel_tgt = t_min;
        sel_cur = bus.cur_min;
        sel_mod = MIN_N;
        case (field)
            F_MONTH: begin
                sel_tgt = t_month;
                sel_cur = bus.cur_month;
                sel_mod = MONTH_N;
            end
            F_DATE: begin
                sel_tgt = t_date;
                sel_cur = bus.cur_date;
                sel_mod = days_in_month(t_month);
            end
            F_DAY: begin
                sel_tgt = t_dys;
                sel_cur = bus.cur_dys;
                sel_mod = DYS_N;
            end
            F_HRS: begin
                sel_tgt = t_hrs;
                sel_cur = bus.cur_hrs;
                sel_mod = HRS_N;
            end
            default: begin
                sel_tgt = t_min;
                sel_cur = bus.cur_min;
                sel_mod = MIN_N;
            end
        endcase
    end

    assign range_bad   = (t_min   >= MIN_N)   || (t_hrs >= HRS_N) ||
                         (t_dys   >= DYS_N)   || (t_month >= MONTH_N) ||
                         (t_date  >= days_in_month(t_month));
    assign field_match = (sel_cur == sel_tgt);
    // A full lap of strobes without a match means the counter is not following.
    assign step_spent  = ({1'b0, step} == sel_mod);

    // Sequencer with registered outputs; done/err/strobes default to one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            field     <= F_MONTH;
            step      <= '0;
            t_min     <= '0;
            t_hrs     <= '0;
            t_dys     <= '0;
            t_date    <= '0;
            t_month   <= '0;
            timeset_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            strb_r    <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            strb_r <= '0;
            if (bus.abort && (state != S_IDLE)) begin
                state     <= S_IDLE;
                timeset_r <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            t_min   <= bus.tgt_min;
                            t_hrs   <= bus.tgt_hrs;
                            t_dys   <= bus.tgt_dys;
                            t_date  <= bus.tgt_date;
                            t_month <= bus.tgt_month;
                            field   <= F_MONTH;
                            step    <= '0;
                            busy_r  <= 1'b1;
                            state   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (range_bad) begin
                            err_r  <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= S_ERR;
                        end else begin
                            timeset_r <= 1'b1;
                            state     <= S_CMP;
                        end
                    end
                    S_CMP: begin
                        if (field_match) begin
                            step <= '0;
                            if (field == F_MIN) begin
                                done_r    <= 1'b1;
                                timeset_r <= 1'b0;
                                busy_r    <= 1'b0;
                                state     <= S_DONE;
                            end else begin
                                field <= next_field(field);
                            end
                        end else if (step_spent) begin
                            err_r     <= 1'b1;
                            timeset_r <= 1'b0;
                            busy_r    <= 1'b0;
                            state     <= S_ERR;
                        end else begin
                            strb_r <= field_onehot(field);
                            state  <= S_ADV;
                        end
                    end
                    S_ADV: begin
                        step  <= step + 6'd1;
                        state <= S_CMP;
                    end
                    S_DONE:  state <= S_IDLE;
                    S_ERR:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.Timeset  = timeset_r;
    assign bus.Monthadv = strb_r[0];
    assign bus.Dateadv  = strb_r[1];
    assign bus.Dayadv   = strb_r[2];
    assign bus.Hrsadv   = strb_r[3];
    assign bus.Minadv   = strb_r[4];
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_clock_autoset.sv
// Bench for clock_autoset: behavioural mod-N clock model driven by the
// sequencer's strobes, expectations queued per sequence and drained against
// what was observed on the bus.
module tb_clock_autoset;

    import clock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    clock_autoset_if bus ();

    clock_autoset dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock model ----------------
    logic [6:0] m_min, m_hrs, m_dys, m_date, m_month;
    logic [6:0] ld_min, ld_hrs, ld_dys, ld_date, ld_month;
    logic       ld = 1'b0;
    logic       freeze_hrs = 1'b0;

    always @(posedge clk) begin
        if (ld) begin
            m_min <= ld_min; m_hrs <= ld_hrs; m_dys <= ld_dys;
            m_date <= ld_date; m_month <= ld_month;
        end else begin
            if (bus.Minadv)   m_min   <= (m_min   == 7'd59) ? 7'd0 : m_min + 7'd1;
            if (bus.Hrsadv && !freeze_hrs)
                              m_hrs   <= (m_hrs   == 7'd23) ? 7'd0 : m_hrs + 7'd1;
            if (bus.Dayadv)   m_dys   <= (m_dys   == 7'd6)  ? 7'd0 : m_dys + 7'd1;
            if (bus.Dateadv)  m_date  <= (m_date + 7'd1 >= days_in_month(m_month)) ? 7'd0 : m_date + 7'd1;
            if (bus.Monthadv) m_month <= (m_month == 7'd11) ? 7'd0 : m_month + 7'd1;
        end
    end

    assign bus.cur_min   = m_min;
    assign bus.cur_hrs   = m_hrs;
    assign bus.cur_dys   = m_dys;
    assign bus.cur_date  = m_date;
    assign bus.cur_month = m_month;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        string test;
        string key;
        int    val;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input string test, input string key, input int val);
        exp_t e;
        e.test = test; e.key = key; e.val = val;
        exp_q.push_back(e);
    endtask

    // ---------------- observations ----------------
    int o_done_cyc, o_err_cyc, o_done_cnt, o_err_cnt;
    int o_ts_first, o_ts_last, o_ts_cnt, o_busy_first, o_busy_last;
    int o_n_min, o_n_hrs, o_n_dys, o_n_date, o_n_month, o_n_all;
    int o_multi, o_consec;

    function automatic int obs_of(input string key);
        case (key)
            "done_cyc":   return o_done_cyc;
            "err_cyc":    return o_err_cyc;
            "done_cnt":   return o_done_cnt;
            "err_cnt":    return o_err_cnt;
            "ts_first":   return o_ts_first;
            "ts_last":    return o_ts_last;
            "ts_cnt":     return o_ts_cnt;
            "busy_first": return o_busy_first;
            "busy_last":  return o_busy_last;
            "n_min":      return o_n_min;
            "n_hrs":      return o_n_hrs;
            "n_dys":      return o_n_dys;
            "n_date":     return o_n_date;
            "n_month":    return o_n_month;
            "n_all":      return o_n_all;
            "multi":      return o_multi;
            "consec":     return o_consec;
            default:      return -999;
        endcase
    endfunction

    task automatic drain_exp();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({e.test, ".", e.key}, obs_of(e.key), e.val);
        end
    endtask

    task automatic load_clock(input int mo, input int da, input int dy, input int h, input int mi);
        @(negedge clk);
        ld_month = 7'(mo); ld_date = 7'(da); ld_dys = 7'(dy); ld_hrs = 7'(h); ld_min = 7'(mi);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic set_tgt(input int mo, input int da, input int dy, input int h, input int mi);
        bus.tgt_month = 7'(mo); bus.tgt_date = 7'(da); bus.tgt_dys = 7'(dy);
        bus.tgt_hrs = 7'(h); bus.tgt_min = 7'(mi);
    endtask

    // start is high across the edge closing cycle 0; cycle c is sampled at its negedge.
    task automatic run_seq(input int maxc, input int restart_at, input int abort_at);
        int  n;
        bit  prev_strb;
        int  end_cyc;
        o_done_cyc = -1; o_err_cyc = -1; o_done_cnt = 0; o_err_cnt = 0;
        o_ts_first = -1; o_ts_last = -1; o_ts_cnt = 0; o_busy_first = -1; o_busy_last = -1;
        o_n_min = 0; o_n_hrs = 0; o_n_dys = 0; o_n_date = 0; o_n_month = 0; o_n_all = 0;
        o_multi = 0; o_consec = 0;
        prev_strb = 1'b0;
        end_cyc = -1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            n = int'(bus.Monthadv) + int'(bus.Dateadv) + int'(bus.Dayadv) +
                int'(bus.Hrsadv) + int'(bus.Minadv);
            o_n_month += int'(bus.Monthadv);
            o_n_date  += int'(bus.Dateadv);
            o_n_dys   += int'(bus.Dayadv);
            o_n_hrs   += int'(bus.Hrsadv);
            o_n_min   += int'(bus.Minadv);
            o_n_all   += n;
            if (n > 1) o_multi++;
            if (n > 0 && prev_strb) o_consec++;
            prev_strb = (n > 0);
            if (bus.Timeset) begin
                if (o_ts_first < 0) o_ts_first = c;
                o_ts_last = c;
                o_ts_cnt++;
            end
            if (bus.busy) begin
                if (o_busy_first < 0) o_busy_first = c;
                o_busy_last = c;
            end
            if (bus.done) begin
                o_done_cnt++;
                if (o_done_cyc < 0) o_done_cyc = c;
                if (end_cyc < 0) end_cyc = c;
            end
            if (bus.err) begin
                o_err_cnt++;
                if (o_err_cyc < 0) o_err_cyc = c;
                if (end_cyc < 0) end_cyc = c;
            end
            if (c == restart_at) begin
                bus.start   = 1'b1;
                bus.tgt_min = 7'd10;
            end
            if (c == abort_at) bus.abort = 1'b1;
            if (end_cyc >= 0 && c >= end_cyc + 2) break;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_tgt(0, 0, 0, 0, 0);
        ld_month = '0; ld_date = '0; ld_dys = '0; ld_hrs = '0; ld_min = '0;

        // reset state
        repeat (2) @(negedge clk);
        check_val("reset.Timeset", int'(bus.Timeset), 0);
        check_val("reset.busy",    int'(bus.busy), 0);
        check_val("reset.done",    int'(bus.done), 0);
        check_val("reset.err",     int'(bus.err), 0);
        check_val("reset.strobes", int'({bus.Monthadv, bus.Dateadv, bus.Dayadv, bus.Hrsadv, bus.Minadv}), 0);
        rst = 1'b0;

        // already matching: no strobes, Timeset 2..6, done in 7
        load_clock(4, 9, 2, 13, 30);
        set_tgt(4, 9, 2, 13, 30);
        push_exp("match", "done_cyc", 7);
        push_exp("match", "done_cnt", 1);
        push_exp("match", "err_cnt", 0);
        push_exp("match", "ts_first", 2);
        push_exp("match", "ts_last", 6);
        push_exp("match", "busy_first", 1);
        push_exp("match", "busy_last", 6);
        push_exp("match", "n_all", 0);
        run_seq(30, -1, -1);
        drain_exp();

        // minute wrap 58 -> 3: five strobes on alternate cycles
        load_clock(4, 9, 2, 13, 58);
        set_tgt(4, 9, 2, 13, 3);
        push_exp("wrap", "n_min", 5);
        push_exp("wrap", "n_all", 5);
        push_exp("wrap", "consec", 0);
        push_exp("wrap", "done_cyc", 17);
        push_exp("wrap", "ts_last", 16);
        push_exp("wrap", "err_cnt", 0);
        run_seq(40, -1, -1);
        drain_exp();
        check_val("wrap.model_min", int'(m_min), 3);

        // Feb 30th (0-based date 29) is out of range
        load_clock(4, 9, 2, 13, 30);
        set_tgt(1, 29, 2, 13, 30);
        push_exp("feb29", "err_cyc", 2);
        push_exp("feb29", "err_cnt", 1);
        push_exp("feb29", "done_cnt", 0);
        push_exp("feb29", "ts_cnt", 0);
        push_exp("feb29", "n_all", 0);
        push_exp("feb29", "busy_last", 1);
        run_seq(20, -1, -1);
        drain_exp();

        // other range limits: minute 60, Apr 31st (date 30)
        set_tgt(4, 9, 2, 13, 60);
        push_exp("min60", "err_cyc", 2);
        push_exp("min60", "ts_cnt", 0);
        run_seq(20, -1, -1);
        drain_exp();
        set_tgt(3, 30, 2, 13, 30);
        push_exp("apr31", "err_cyc", 2);
        run_seq(20, -1, -1);
        drain_exp();

        // frozen hour counter: 24 strobes then err
        load_clock(4, 9, 2, 0, 30);
        set_tgt(4, 9, 2, 5, 30);
        freeze_hrs = 1'b1;
        push_exp("stuck", "n_hrs", 24);
        push_exp("stuck", "n_all", 24);
        push_exp("stuck", "err_cyc", 54);
        push_exp("stuck", "done_cnt", 0);
        push_exp("stuck", "ts_last", 53);
        push_exp("stuck", "consec", 0);
        run_seq(90, -1, -1);
        drain_exp();
        freeze_hrs = 1'b0;

        // start re-pulsed while busy with a different target: ignored
        load_clock(4, 9, 2, 13, 58);
        set_tgt(4, 9, 2, 13, 3);
        push_exp("restart", "n_min", 5);
        push_exp("restart", "done_cyc", 17);
        push_exp("restart", "done_cnt", 1);
        run_seq(40, 4, -1);
        drain_exp();
        check_val("restart.model_min", int'(m_min), 3);

        // abort while walking the date field
        load_clock(4, 5, 2, 13, 30);
        set_tgt(4, 9, 2, 13, 30);
        push_exp("abort", "n_date", 1);
        push_exp("abort", "ts_last", 5);
        push_exp("abort", "busy_last", 5);
        push_exp("abort", "done_cnt", 0);
        push_exp("abort", "err_cnt", 0);
        run_seq(20, -1, 5);
        drain_exp();

        // asynchronous reset while Minadv is high
        load_clock(4, 9, 2, 13, 50);
        set_tgt(4, 9, 2, 13, 3);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !bus.Minadv; i++) @(negedge clk);
        check_val("rst.minadv_seen", int'(bus.Minadv), 1);
        #2 rst = 1'b1;
        #1;
        check_val("rst.Minadv",  int'(bus.Minadv), 0);
        check_val("rst.Timeset", int'(bus.Timeset), 0);
        check_val("rst.busy",    int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst.state", int'(dut.state), int'(S_IDLE));
        s = (3 - int'(m_min) + 60) % 60;
        push_exp("after_rst", "n_min", s);
        push_exp("after_rst", "done_cyc", 7 + 2 * s);
        push_exp("after_rst", "err_cnt", 0);
        run_seq(150, -1, -1);
        drain_exp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
